// File: rtl/seq_phase_controller_pkg.sv
// seq_pkg: shared types and constants for the phase sequencer.
//   seq_state_t : sequencer state encoding (WAIT only exists when the
//                 SEQ_STEP_EN macro is defined)
//   NPHASE_DEF  : default number of phases per instruction
//   FETCH_LAST  : last fetch phase; phases above it are execute phases
//   IDX_W       : width of the phase index output
package seq_pkg;
  localparam int NPHASE_DEF = 6;
  localparam int FETCH_LAST = 3;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PHASE = 3'd1,
    S_GAP   = 3'd2,
    S_HALT  = 3'd3
`ifdef SEQ_STEP_EN
    , S_WAIT = 3'd4
`endif
  } seq_state_t;
endpackage

// File: rtl/seq_phase_controller_if.sv
// seq_phase_controller_if: control/strobe bundle of the phase sequencer.
//   Inputs to the sequencer : run, halt_req, resume, instr_done
//                             (+ step_en, step with SEQ_STEP_EN defined)
//   Outputs of the sequencer: wseq[NPHASE:1], phase_idx, gap, fetch,
//                             halted, instr_cnt
//   master modport: the environment driving the sequencer
//   slave modport : the sequencer itself
interface seq_phase_controller_if #(
  parameter int NPHASE = seq_pkg::NPHASE_DEF,
  parameter int CNT_W  = 16
);
  logic                       run;
  logic                       halt_req;
  logic                       resume;
  logic                       instr_done;
  logic [NPHASE:1]            wseq;
  logic [seq_pkg::IDX_W-1:0]  phase_idx;
  logic                       gap;
  logic                       fetch;
  logic                       halted;
  logic [CNT_W-1:0]           instr_cnt;
`ifdef SEQ_STEP_EN
  logic                       step_en;
  logic                       step;
`endif

  modport master (
    output run, halt_req, resume, instr_done,
`ifdef SEQ_STEP_EN
    output step_en, step,
`endif
    input  wseq, phase_idx, gap, fetch, halted, instr_cnt
  );

  modport slave (
    input  run, halt_req, resume, instr_done,
`ifdef SEQ_STEP_EN
    input  step_en, step,
`endif
    output wseq, phase_idx, gap, fetch, halted, instr_cnt
  );
endinterface

// File: rtl/seq_phase_controller_ring.sv
// seq_phase_ring: one-hot phase register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : all strobes off and index back to 0 (IDLE)
//   restart    : strobe phase 1
//   advance    : strobe the phase after the current index
//   blank      : strobes off, index kept (gap / wait / halt)
//   wseq       : registered one-hot strobes
//   phase_idx  : active or last phase number
// Priority: clear > restart > advance > blank.
module seq_phase_ring
  import seq_pkg::*;
#(
  parameter int NPHASE = NPHASE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              restart,
  input  logic              blank,
  input  logic              clear,
  output logic [NPHASE:1]   wseq,
  output logic [IDX_W-1:0]  phase_idx
);
  logic [IDX_W-1:0] nxt;

  function automatic logic [NPHASE:1] onehot(input logic [IDX_W-1:0] p);
    logic [NPHASE:1] v;
    v = '0;
    for (int i = 1; i <= NPHASE; i++)
      if (p == IDX_W'(i)) v[i] = 1'b1;
    return v;
  endfunction

  assign nxt = phase_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wseq      <= '0;
      phase_idx <= '0;
    end else if (clear) begin
      wseq      <= '0;
      phase_idx <= '0;
    end else if (restart) begin
      wseq      <= onehot(IDX_W'(1));
      phase_idx <= IDX_W'(1);
    end else if (advance) begin
      wseq      <= onehot(nxt);
      phase_idx <= nxt;
    end else if (blank) begin
      wseq      <= '0;
    end
  end
endmodule

// File: rtl/seq_phase_controller.sv
// seq_phase_controller: machine-cycle phase sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_phase_controller_if.slave (run/halt/resume/instr_done
//                in; wseq, phase_idx, gap, fetch, halted, instr_cnt out)
// Parameters: NPHASE phases per instruction, GAP dead cycles (0..3) after
// every phase, CNT_W instruction counter width.
// Optional: define SEQ_STEP_EN to add step_en/step and the WAIT state.
module seq_phase_controller
  import seq_pkg::*;
#(
  parameter int NPHASE = NPHASE_DEF,
  parameter int GAP    = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_phase_controller_if.slave  bus
);
  seq_state_t        state_q, state_d;
  logic [1:0]        gcnt_q, gcnt_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              advance, restart, blank, clear;
  logic              adv_pt, go, last, exec_done;
  logic [NPHASE:1]   wseq;
  logic [IDX_W-1:0]  idx;

  seq_phase_ring #(.NPHASE(NPHASE)) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .restart   (restart),
    .blank     (blank),
    .clear     (clear),
    .wseq      (wseq),
    .phase_idx (idx)
  );

  // Early termination is only honoured while an execute phase is strobing.
  assign exec_done = (state_q == S_PHASE) && bus.instr_done && (idx > IDX_W'(FETCH_LAST));
  assign last      = done_q || (idx == IDX_W'(NPHASE)) || exec_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gcnt_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    pend_d  = pend_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    restart = 1'b0;
    blank   = 1'b0;
    clear   = 1'b0;
    adv_pt  = 1'b0;
    go      = 1'b0;

    if (state_q != S_HALT && bus.halt_req) pend_d = 1'b1;

    case (state_q)
      S_IDLE: if (bus.run) begin
        state_d = S_PHASE;
        restart = 1'b1;
      end
      S_PHASE: begin
        blank = 1'b1;
        if (exec_done) done_d = 1'b1;
        if (GAP > 0) begin
          state_d = S_GAP;
          gcnt_d  = 2'(GAP - 1);
        end else begin
          adv_pt = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q == 2'd0) adv_pt = 1'b1;
        else                gcnt_d = gcnt_q - 2'd1;
      end
      S_HALT: if (bus.resume) begin
        // A halt_req coinciding with resume allows exactly one instruction.
        pend_d = bus.halt_req;
        if (bus.run) begin
          state_d = S_PHASE;
          restart = 1'b1;
        end else begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
`ifdef SEQ_STEP_EN
      S_WAIT: if (bus.step || !bus.step_en) go = 1'b1;
`endif
      default: begin
        state_d = S_IDLE;
        clear   = 1'b1;
      end
    endcase

`ifdef SEQ_STEP_EN
    if (adv_pt && bus.step_en) state_d = S_WAIT;
    else if (adv_pt)           go      = 1'b1;
`else
    if (adv_pt) go = 1'b1;
`endif

    // Move to the next phase, or take the instruction boundary.
    if (go) begin
      done_d = 1'b0;
      if (last) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (pend_q || bus.halt_req) begin
          state_d = S_HALT;
          pend_d  = 1'b0;
          blank   = 1'b1;
        end else if (!bus.run) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else begin
          state_d = S_PHASE;
          restart = 1'b1;
        end
      end else begin
        state_d = S_PHASE;
        advance = 1'b1;
      end
    end
  end

  assign bus.wseq      = wseq;
  assign bus.phase_idx = idx;
  assign bus.gap       = (state_q == S_GAP);
  assign bus.fetch     = |wseq[FETCH_LAST:1];
  assign bus.halted    = (state_q == S_HALT);
  assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_seq_phase_controller.sv
// tb_seq_phase_controller: scoreboard bench for seq_phase_controller with
// default parameters (NPHASE=6, GAP=1, CNT_W=16). Step-mode cases are
// compiled when SEQ_STEP_EN is defined.
module tb_seq_phase_controller;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_phase_controller_if #(.NPHASE(6), .CNT_W(16)) bus();

  seq_phase_controller #(.NPHASE(6), .GAP(1), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [6:1]  w;
    logic [2:0]  idx;
    logic        g;
    logic        f;
    logic        h;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0;
  int base = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- expectation helpers ----------------
  task automatic push(input int n, input string nm, input logic [6:1] w,
                      input logic [2:0] idx, input logic g, input logic h,
                      input logic [15:0] c);
    exp_t e;
    e.cyc = base + n; e.name = nm; e.w = w; e.idx = idx;
    e.g = g; e.f = |w[3:1]; e.h = h; e.cnt = c;
    sbq.push_back(e);
  endtask

  task automatic exp_ph(input int n, input int k, input logic [15:0] c);
    logic [6:1] w;
    w = '0;
    w[k] = 1'b1;
    push(n, "phase", w, 3'(k), 1'b0, 1'b0, c);
  endtask

  task automatic exp_gp(input int n, input int k, input logic [15:0] c);
    push(n, "gap", 6'b0, 3'(k), 1'b1, 1'b0, c);
  endtask

  task automatic exp_zero(input int n, input string nm, input logic [15:0] c);
    push(n, nm, 6'b0, 3'd0, 1'b0, 1'b0, c);
  endtask

  task automatic exp_halt(input int n, input int k, input logic [15:0] c);
    push(n, "halt", 6'b0, 3'(k), 1'b0, 1'b1, c);
  endtask

  task automatic exp_instr(input int s, input logic [15:0] c);
    for (int k = 1; k <= 6; k++) begin
      exp_ph(s + 2*k - 2, k, c);
      exp_gp(s + 2*k - 1, k, c);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int n);
    while (cyc < base + n) tick();
  endtask

  task automatic start_test();
    bus.run = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0; bus.instr_done = 1'b0;
`ifdef SEQ_STEP_EN
    bus.step_en = 1'b0; bus.step = 1'b0;
`endif
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    base = cyc;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    logic [27:0] act, req;
    n_tests++;
    if ($countones(bus.wseq) > 1 || (bus.gap && |bus.wseq)) begin
      n_fail++;
      $display("FAIL invariant cyc=%0d wseq=%b gap=%b", cyc - base, bus.wseq, bus.gap);
    end
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_%s expected cycle %0d never sampled", e.name, e.cyc - base);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      act = {bus.wseq, bus.phase_idx, bus.gap, bus.fetch, bus.halted, bus.instr_cnt};
      req = {e.w, e.idx, e.g, e.f, e.h, e.cnt};
      n_tests++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got wseq=%b idx=%0d gap=%b fetch=%b halted=%b cnt=%h want wseq=%b idx=%0d gap=%b fetch=%b halted=%b cnt=%h",
                 e.name, cyc - base, bus.wseq, bus.phase_idx, bus.gap, bus.fetch, bus.halted,
                 bus.instr_cnt, e.w, e.idx, e.g, e.f, e.h, e.cnt);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog simulation time limit reached, %0d expectations pending", sbq.size());
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    // Free-running instruction, then run dropped mid-instruction.
    start_test();
    exp_zero(0, "idle_after_reset", 16'd0);
    exp_instr(1, 16'd0);
    exp_instr(13, 16'd1);
    exp_zero(25, "run_drop_idle", 16'd2);
    exp_zero(26, "run_drop_idle", 16'd2);
    bus.run = 1'b1;
    at(13); bus.run = 1'b0;
    at(27);

    // Early termination in phase 4; instr_done in phase 2 ignored.
    start_test();
    exp_zero(0, "idle", 16'd0);
    exp_ph(1, 1, 16'd0); exp_gp(2, 1, 16'd0);
    exp_ph(3, 2, 16'd0); exp_gp(4, 2, 16'd0);
    exp_ph(5, 3, 16'd0); exp_gp(6, 3, 16'd0);
    exp_ph(7, 4, 16'd0); exp_gp(8, 4, 16'd0);
    exp_instr(9, 16'd1);
    exp_ph(21, 1, 16'd2);
    bus.run = 1'b1;
    at(7);  bus.instr_done = 1'b1; tick(); bus.instr_done = 1'b0;
    at(11); bus.instr_done = 1'b1; tick(); bus.instr_done = 1'b0;
    at(22); bus.run = 1'b0;

    // Halt at boundary, resume, then resume+halt_req for a single instruction.
    start_test();
    exp_zero(0, "idle", 16'd0);
    exp_instr(1, 16'd0);
    for (int n = 13; n <= 20; n++) exp_halt(n, 6, 16'd1);
    exp_instr(21, 16'd1);
    for (int n = 33; n <= 36; n++) exp_halt(n, 6, 16'd2);
    exp_instr(37, 16'd2);
    exp_halt(49, 6, 16'd3);
    exp_halt(50, 6, 16'd3);
    bus.run = 1'b1;
    at(4);  bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    at(20); bus.resume = 1'b1;   tick(); bus.resume = 1'b0;
    at(23); bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    at(36); bus.resume = 1'b1; bus.halt_req = 1'b1; tick();
    bus.resume = 1'b0; bus.halt_req = 1'b0;
    at(51); bus.run = 1'b0;

    // Asynchronous reset during phase 3, restart after release.
    start_test();
    exp_zero(0, "idle", 16'd0);
    exp_ph(1, 1, 16'd0); exp_gp(2, 1, 16'd0);
    exp_ph(3, 2, 16'd0); exp_gp(4, 2, 16'd0);
    exp_zero(5, "async_reset", 16'd0);
    exp_zero(6, "in_reset", 16'd0);
    exp_zero(7, "reset_release", 16'd0);
    exp_ph(8, 1, 16'd0); exp_gp(9, 1, 16'd0);
    exp_ph(10, 2, 16'd0);
    bus.run = 1'b1;
    at(5); rst_n = 1'b0;
    at(7); rst_n = 1'b1;
    at(11); bus.run = 1'b0;

    // Instruction counter wrap from 0xFFFF.
    start_test();
    push(0, "preload", 6'b0, 3'd0, 1'b0, 1'b0, 16'hFFFF);
    exp_instr(1, 16'hFFFF);
    exp_ph(13, 1, 16'h0000);
    force dut.cnt_q = 16'hFFFF;
    bus.run = 1'b1;
    tick();
    release dut.cnt_q;
    at(14); bus.run = 1'b0;

`ifdef SEQ_STEP_EN
    // Step mode: one phase per step, stray step ignored, step_en release.
    start_test();
    bus.step_en = 1'b1;
    exp_zero(0, "idle", 16'd0);
    exp_ph(1, 1, 16'd0); exp_gp(2, 1, 16'd0);
    for (int n = 3; n <= 6; n++) push(n, "wait", 6'b0, 3'd1, 1'b0, 1'b0, 16'd0);
    exp_ph(7, 2, 16'd0); exp_gp(8, 2, 16'd0);
    for (int n = 9; n <= 10; n++) push(n, "wait", 6'b0, 3'd2, 1'b0, 1'b0, 16'd0);
    exp_ph(11, 3, 16'd0); exp_gp(12, 3, 16'd0);
    exp_ph(13, 4, 16'd0);
    bus.run = 1'b1;
    at(6);  bus.step = 1'b1; tick(); bus.step = 1'b0;
    at(7);  bus.step = 1'b1; tick(); bus.step = 1'b0;
    at(10); bus.step_en = 1'b0;
    at(14); bus.run = 1'b0;
`endif

    tick();
    tick();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations got %0d pending want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
